serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
- Bit-serial N-bit adder built around a half-adder pair (full-adder cell) and a carry flip-flop.
- Consumes two parallel operands, processes them LSB-first, one bit per clock.
- Returns a parallel sum and a carry-out with a one-cycle done pulse.
- This is the sequential stage that drives the lab's combinational HalfAdder cell across multi-bit operands.

Parameters:
- WIDTH, 4, operand and sum width in bits. Legal values are 1 to 32.

Ports:
- clk      input   1      single system clock; all state updates on the rising edge
- rst      input   1      synchronous, active-high reset
- start    input   1      request to add a_in and b_in; sampled only when ready=1
- a_in     input   WIDTH  operand A, captured on the accepted start edge
- b_in     input   WIDTH  operand B, captured on the accepted start edge
- ready    output  1      1 in IDLE only; start is accepted only when this is 1
- busy     output  1      1 in SHIFT state
- done     output  1      one-cycle pulse; sum_out and carry_out are valid from this cycle
- sum_out  output  WIDTH  (a+b) mod 2^WIDTH; held until the next completion
- carry_out output 1      bit WIDTH of a+b; held with sum_out

Behaviour:
- Clock and reset:
  - One clock domain (clk). Reset is synchronous and active-high (rst).
  - rst has priority over every other input, including start on the same edge.
- Reset values:
  - State = IDLE.
  - ready=1, busy=0, done=0, sum_out=0, carry_out=0.
  - Internal shift registers, carry flip-flop and bit counter = 0.
- State machine (IDLE, SHIFT, DONE):
  - IDLE: ready=1.
    - On an edge with start=1: load a_in and b_in into shift registers, clear the carry flip-flop, set cnt=0, go to SHIFT.
    - With start=0: stay in IDLE.
  - SHIFT: busy=1. On each edge:
    - s = a_sh[0]^b_sh[0]^c and c <= majority(a_sh[0], b_sh[0], c).
    - s is shifted into the MSB of the internal result register, which shifts right.
    - a_sh and b_sh shift right; cnt increments.
    - On the edge where cnt==WIDTH-1: load sum_out with the completed result (including that final bit), load carry_out with the final carry, go to DONE.
  - DONE: done=1 for exactly one cycle, then unconditionally go to IDLE.
    - ready=0 here, so start during DONE is ignored.
- Latency and throughput:
  - Start accepted on edge E0; done is high in the cycle after edge E0+WIDTH.
  - Back-to-back throughput is one add per WIDTH+2 cycles.
  - If start is held high continuously, a new add launches on every IDLE edge.
- Outputs and handshake:
  - sum_out and carry_out change only on the SHIFT→DONE transition or on reset. They never show partial results.
  - start while busy or during DONE is dropped silently and is not queued.
  - a_in and b_in are don't-care except on the accepting edge. Changing them mid-operation does not affect the result.
- Arithmetic:
  - Unsigned.
  - {carry_out, sum_out} == a_in + b_in, computed at WIDTH+1 bits.
  - Wrap-around is expressed only through carry_out.
- Boundary conditions:
  - WIDTH=1: SHIFT lasts exactly one cycle.
  - All-ones + all-ones gives sum = all-ones minus 1 with carry_out=1.
  - 0+0 gives 0, carry_out 0.
- Reset mid-operation (rst in SHIFT or DONE):
  - Abort the add and return to IDLE on that edge.
  - sum_out and carry_out clear to 0; no done pulse.
- Output decode:
  - done, ready and busy are decoded from the state register only. They are glitch-free registered levels, with no combinational path from start.

Test Plan:
- WIDTH=4, rst 2 cycles, then start with a=3, b=5 → done high exactly 4 cycles after the start edge; sum_out=8, carry_out=0; ready returns to 1 the next cycle.
- a=15, b=1, then a=15, b=15 back-to-back with start held high → sum=0/carry=1, then sum=14/carry=1. Each done is a single cycle, and the launches are 6 cycles apart.
- Start with a=6, b=9; 1 cycle later pulse start again with a=1, b=1 and change a_in/b_in → second start ignored; result sum=15, carry=0; exactly one done.
- Start with a=7, b=7; assert rst on the 2nd SHIFT cycle → next cycle ready=1, busy=0, sum_out=0, carry_out=0, and no done appears within 10 cycles.
- Exhaustive loop over all 256 (a,b) pairs at WIDTH=4 → every {carry_out, sum_out} == a+b, and busy is high for exactly 4 cycles per add.
- WIDTH=1 instance: (0,0), (0,1), (1,0), (1,1) → sum/carry = 0/0, 1/0, 1/0, 0/1 (half-adder truth table); done 1 cycle after each accepted start.

Source files
------------

// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
// Bit-serial unsigned adder. Two WIDTH-bit operands are captured in parallel,
// added LSB-first one bit per clock through a full-adder cell built from two
// half adders plus a carry flip-flop, and returned as a parallel sum with
// carry-out and a one-cycle done pulse.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset, overrides start
//   start      add request, accepted only while ready=1
//   a_in,b_in  operands, captured on the accepting edge only
//   ready      1 in IDLE
//   busy       1 in SHIFT
//   done       one-cycle pulse, sum_out/carry_out valid from this cycle
//   sum_out    (a+b) mod 2^WIDTH, held until the next completion
//   carry_out  bit WIDTH of a+b, held with sum_out
//   dbg_state  current FSM state (IDLE=0, SHIFT=1, DONE=2)
//
// Handshake: start is a request qualified by ready. An edge with start=1 and
// ready=1 launches one add; start at any other time is dropped, never queued.
// The result is announced by done for exactly one cycle and stays on
// sum_out/carry_out until the next add completes or reset.
// -----------------------------------------------------------------------------
module serial_adder #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             carry_out,
  output logic [1:0]       dbg_state
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  // Counter must hold WIDTH-1; keep at least one bit for WIDTH=1.
  localparam int              CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_res;
  logic             r_carry;
  logic [CNT_W-1:0] r_cnt;

  // Full-adder cell as two half adders: (a,b) then (partial sum, carry).
  logic             w_ha1_s;
  logic             w_ha1_c;
  logic             w_ha2_s;
  logic             w_ha2_c;
  logic             w_carry_next;
  logic [WIDTH-1:0] w_res_next;

  assign w_ha1_s      = r_a_sh[0] ^ r_b_sh[0];
  assign w_ha1_c      = r_a_sh[0] & r_b_sh[0];
  assign w_ha2_s      = w_ha1_s ^ r_carry;
  assign w_ha2_c      = w_ha1_s & r_carry;
  assign w_carry_next = w_ha1_c | w_ha2_c;

  // New sum bit enters at the MSB while the result shifts right, so after
  // WIDTH steps bit 0 of the sum has reached position 0. Written as a shift
  // so that WIDTH=1 needs no special case.
  assign w_res_next = (r_res >> 1) | (WIDTH'(w_ha2_s) << (WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_a_sh    <= '0;
      r_b_sh    <= '0;
      r_res     <= '0;
      r_carry   <= 1'b0;
      r_cnt     <= '0;
      sum_out   <= '0;
      carry_out <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a_sh  <= a_in;
            r_b_sh  <= b_in;
            r_res   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_a_sh  <= r_a_sh >> 1;
          r_b_sh  <= r_b_sh >> 1;
          r_res   <= w_res_next;
          r_carry <= w_carry_next;
          r_cnt   <= r_cnt + CNT_W'(1);
          // Publish only the completed word; outputs never show partials.
          if (r_cnt == CNT_LAST) begin
            sum_out   <= w_res_next;
            carry_out <= w_carry_next;
            r_state   <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Status levels decode the state register only; no path from start.
  assign ready     = (r_state == S_IDLE);
  assign busy      = (r_state == S_SHIFT);
  assign done      = (r_state == S_DONE);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_adder
// Directed bench for serial_adder at WIDTH=4 and WIDTH=1. Drivers push the
// expected {carry,sum} and completion cycle into queues; monitors pop and
// compare whenever done is seen.
// -----------------------------------------------------------------------------
module tb_serial_adder;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  // ---------------- WIDTH=4 instance ----------------
  logic       start4 = 1'b0;
  logic [3:0] a4 = '0;
  logic [3:0] b4 = '0;
  logic       ready4, busy4, done4, carry4;
  logic [3:0] sum4;
  logic [1:0] st4;

  serial_adder #(.WIDTH(4)) u_dut4 (
    .clk       (clk),
    .rst       (rst),
    .start     (start4),
    .a_in      (a4),
    .b_in      (b4),
    .ready     (ready4),
    .busy      (busy4),
    .done      (done4),
    .sum_out   (sum4),
    .carry_out (carry4),
    .dbg_state (st4)
  );

  // ---------------- WIDTH=1 instance ----------------
  logic       start1 = 1'b0;
  logic [0:0] a1 = '0;
  logic [0:0] b1 = '0;
  logic       ready1, busy1, done1, carry1;
  logic [0:0] sum1;
  logic [1:0] st1;

  serial_adder #(.WIDTH(1)) u_dut1 (
    .clk       (clk),
    .rst       (rst),
    .start     (start1),
    .a_in      (a1),
    .b_in      (b1),
    .ready     (ready1),
    .busy      (busy1),
    .done      (done1),
    .sum_out   (sum1),
    .carry_out (carry1),
    .dbg_state (st1)
  );

  // ---------------- scoreboard ----------------
  logic [4:0] exp_q4[$];
  int         exp_cyc4[$];
  logic [1:0] exp_q1[$];
  int         exp_cyc1[$];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor for the 4-bit instance.
  initial begin
    int         busy_cnt;
    logic       prev_done;
    logic [4:0] e;
    busy_cnt  = 0;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        busy_cnt  = 0;
        prev_done = 1'b0;
      end else begin
        if (busy4) busy_cnt++;
        if (prev_done) begin
          check("ready_after_done4", {ready4, busy4}, 2'b10);
        end
        if (done4) begin
          if (exp_q4.size() == 0) begin
            check("unexpected_done4", 32'd1, 32'd0);
          end else begin
            e = exp_q4.pop_front();
            check("result4", {carry4, sum4}, e);
            check("latency4", cyc, exp_cyc4.pop_front());
            check("busy_len4", busy_cnt, 4);
          end
          busy_cnt = 0;
        end
        prev_done = done4;
      end
    end
  end

  // Monitor for the 1-bit instance.
  initial begin
    int         busy_cnt;
    logic [1:0] e;
    busy_cnt = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        busy_cnt = 0;
      end else begin
        if (busy1) busy_cnt++;
        if (done1) begin
          if (exp_q1.size() == 0) begin
            check("unexpected_done1", 32'd1, 32'd0);
          end else begin
            e = exp_q1.pop_front();
            check("result1", {carry1, sum1}, e);
            check("latency1", cyc, exp_cyc1.pop_front());
            check("busy_len1", busy_cnt, 1);
          end
          busy_cnt = 0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called #1 after a rising edge with the DUT in IDLE; returns #1 after the
  // accepting edge with start low.
  task automatic issue4(input logic [3:0] a, input logic [3:0] b,
                        input logic [4:0] exp);
    a4     = a;
    b4     = b;
    start4 = 1'b1;
    exp_q4.push_back(exp);
    exp_cyc4.push_back(cyc + 1 + 4);
    @(posedge clk); #1;
    start4 = 1'b0;
  endtask

  task automatic issue1(input logic a, input logic b, input logic [1:0] exp);
    a1[0]  = a;
    b1[0]  = b;
    start1 = 1'b1;
    exp_q1.push_back(exp);
    exp_cyc1.push_back(cyc + 1 + 1);
    @(posedge clk); #1;
    start1 = 1'b0;
  endtask

  // Wait (bounded) until every expected result has been seen; returns #1
  // after the edge that brings the DUT back to IDLE.
  task automatic drain4();
    for (int i = 0; i < 40; i++) begin
      if (exp_q4.size() == 0) break;
      @(posedge clk); #1;
    end
    check("drain4", exp_q4.size(), 0);
    exp_q4.delete();
    exp_cyc4.delete();
  endtask

  task automatic drain1();
    for (int i = 0; i < 20; i++) begin
      if (exp_q1.size() == 0) break;
      @(posedge clk); #1;
    end
    check("drain1", exp_q1.size(), 0);
    exp_q1.delete();
    exp_cyc1.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset for two cycles; check reset values while rst is still asserted.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready4", ready4, 1'b1);
    check("rst_busy4", busy4, 1'b0);
    check("rst_done4", done4, 1'b0);
    check("rst_sum4", {carry4, sum4}, 5'h00);
    check("rst_ready1", ready1, 1'b1);
    check("rst_sum1", {carry1, sum1}, 2'b00);
    rst = 1'b0;
    @(posedge clk); #1;

    // 3 + 5 = 8, carry 0.
    issue4(4'd3, 4'd5, 5'h08);
    drain4();

    // Start held high: 15+1 then 15+15, launches 6 cycles apart. Operands
    // change right after the first accept and must not disturb it.
    a4     = 4'd15;
    b4     = 4'd1;
    start4 = 1'b1;
    exp_q4.push_back(5'h10);
    exp_cyc4.push_back(cyc + 1 + 4);
    exp_q4.push_back(5'h1E);
    exp_cyc4.push_back(cyc + 1 + 6 + 4);
    @(posedge clk); #1;
    a4 = 4'd15;
    b4 = 4'd15;
    repeat (6) @(posedge clk);
    #1;
    start4 = 1'b0;
    drain4();

    // 6 + 9 with a second start while busy and operands changed: ignored.
    issue4(4'd6, 4'd9, 5'h0F);
    @(posedge clk); #1;
    a4     = 4'd1;
    b4     = 4'd1;
    start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    a4     = 4'($urandom_range(0, 15));
    b4     = 4'($urandom_range(0, 15));
    drain4();

    // 7 + 7 aborted by reset in the second SHIFT cycle.
    a4     = 4'd7;
    b4     = 4'd7;
    start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_ready4", ready4, 1'b1);
    check("abort_busy4", busy4, 1'b0);
    check("abort_sum4", {carry4, sum4}, 5'h00);
    // Any done in this window is flagged by the monitor (queue is empty).
    repeat (10) @(posedge clk);
    #1;

    // Boundary vectors, then every operand pair.
    issue4(4'd0, 4'd0, 5'h00);
    drain4();
    issue4(4'd15, 4'd15, 5'h1E);
    drain4();
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        issue4(4'(a), 4'(b), 5'(a + b));
        drain4();
      end
    end

    // WIDTH=1: half-adder truth table.
    issue1(1'b0, 1'b0, 2'b00);
    drain1();
    issue1(1'b0, 1'b1, 2'b01);
    drain1();
    issue1(1'b1, 1'b0, 2'b01);
    drain1();
    issue1(1'b1, 1'b1, 2'b10);
    drain1();

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
